// File: rtl/fetch_decoder_if.sv
// Instruction-memory fetch handshake between fetch_decoder (master) and instruction memory (slave).
interface fetch_decoder_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_rdata_i;

  modport master (output imem_req_o, output imem_addr_o, input imem_ack_i, input imem_rdata_i);
  modport slave  (input imem_req_o, input imem_addr_o, output imem_ack_i, output imem_rdata_i);
endinterface

// File: rtl/fetch_decoder.sv
// Fetch/decode stage: assembles 16/32-bit instructions, reads operands, issues one-cycle pulses to execute.
// Optional macro ILLEGAL_TRAP_EN: undefined instructions raise sticky illegal_o and halt fetching.
module fetch_decoder #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_decoder_if.master     bus,
  input  logic [31:0]         gr_i [32],
  output logic [4:0]          destination_o,
  output logic [31:0]         reg1_o,
  output logic [31:0]         reg2_o,
  output logic                increment_bit_o,
  output logic [4:0]          circuit_sel_o,
  output logic [31:0]         fpc_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                illegal_o
`endif
);

  typedef enum logic [1:0] {S_FETCH_LO, S_FETCH_HI, S_HOLD, S_HALT} state_e;

  typedef struct packed {
    logic       def;
    logic [4:0] sel;
    logic [4:0] dest;
    logic       rd1;
    logic       rd2;
    logic       imm;
    logic [1:0] swp;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] h, input logic [15:0] g);
    dec_t d;
    d      = '0;
    d.dest = h[15:11];
    case (h[10:5])
      6'b001110: begin d.def = 1'b1; d.sel = 5'b00001; d.rd1 = 1'b1; d.rd2 = 1'b1; end
      6'b010010: begin d.def = 1'b1; d.sel = 5'b00001; d.imm = 1'b1; d.rd2 = 1'b1; end
      6'b001010: begin d.def = 1'b1; d.sel = 5'b00010; d.rd1 = 1'b1; d.rd2 = 1'b1; end
      6'b111111: begin
        d.dest = g[15:11];
        if (h[4:0] == 5'd0 && g[10:0] == 11'h340) begin
          d.def = 1'b1; d.sel = 5'b00111; d.rd2 = 1'b1; d.swp = 2'd1;
        end else if (h[4:0] == 5'd0 && g[10:0] == 11'h342) begin
          d.def = 1'b1; d.sel = 5'b00110; d.rd2 = 1'b1; d.swp = 2'd2;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic signed [31:0] sext5(input logic signed [4:0] v);
    return {{27{v[4]}}, v};
  endfunction

  function automatic logic [31:0] swap_bytes(input logic [31:0] w, input logic [1:0] mode);
    case (mode)
      2'd1:    return {w[7:0], w[15:8], w[23:16], w[31:24]};
      2'd2:    return {w[23:16], w[31:24], w[7:0], w[15:8]};
      default: return w;
    endcase
  endfunction

  state_e             r_state, w_state_nx;
  logic [31:0]        r_fpc;
  logic               r_req;
  logic [15:0]        r_h, r_g;
  logic               r_last_valid;
  logic [4:0]         r_last_dest;
  logic [4:0]         r_sel_p1, r_dest_p1;
  logic [31:0]        r_reg1_p1, r_reg2_p1;

  logic [15:0]        w_h, w_g;
  dec_t               w_dec;
  logic               w_ack, w_xii_first, w_hazard, w_fire;
  logic               w_issue, w_latch_h, w_latch_g, w_fpc_inc, w_req_nx;
  logic [31:0]        w_gr1, w_gr2, w_reg1, w_reg2;

  // Candidate instruction: live halfword, latched first half + live second half, or fully latched.
  always_comb begin
    w_h = bus.imem_rdata_i;
    w_g = 16'h0000;
    case (r_state)
      S_FETCH_HI: begin w_h = r_h; w_g = bus.imem_rdata_i; end
      S_HOLD:     begin w_h = r_h; w_g = r_g; end
      default: ;
    endcase
  end

  assign w_dec       = decode(w_h, w_g);
  assign w_ack       = bus.imem_ack_i && r_req;
  assign w_xii_first = (r_state == S_FETCH_LO) && (w_h[10:5] == 6'b111111) && (w_h[4:0] == 5'd0);
  assign w_hazard    = r_last_valid && (r_last_dest != 5'd0) && w_dec.def &&
                       ((w_dec.rd1 && w_h[4:0] == r_last_dest) || (w_dec.rd2 && w_h[15:11] == r_last_dest));

  assign w_gr1  = (w_h[4:0] == 5'd0)   ? 32'h0 : gr_i[w_h[4:0]];
  assign w_gr2  = (w_h[15:11] == 5'd0) ? 32'h0 : gr_i[w_h[15:11]];
  assign w_reg1 = w_dec.imm ? sext5(w_h[4:0]) : (w_dec.rd1 ? w_gr1 : 32'h0);
  assign w_reg2 = w_dec.rd2 ? swap_bytes(w_gr2, w_dec.swp) : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH_LO;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_FETCH_LO: if (w_ack) begin
        if (w_xii_first)   w_state_nx = S_FETCH_HI;
        else if (w_hazard) w_state_nx = S_HOLD;
`ifdef ILLEGAL_TRAP_EN
        if (!w_xii_first && !w_dec.def) w_state_nx = S_HALT;
`endif
      end
      S_FETCH_HI: if (w_ack) begin
        w_state_nx = w_hazard ? S_HOLD : S_FETCH_LO;
`ifdef ILLEGAL_TRAP_EN
        if (!w_dec.def) w_state_nx = S_HALT;
`endif
      end
      S_HOLD:  w_state_nx = S_FETCH_LO;
      default: w_state_nx = r_state;
    endcase
  end

  always_comb begin
    w_issue   = 1'b0;
    w_latch_h = 1'b0;
    w_latch_g = 1'b0;
    w_fpc_inc = 1'b0;
    case (r_state)
      S_FETCH_LO: if (w_ack) begin
        w_fpc_inc = 1'b1;
        if (w_xii_first || w_hazard) w_latch_h = 1'b1;
        else                         w_issue   = 1'b1;
      end
      S_FETCH_HI: if (w_ack) begin
        w_fpc_inc = 1'b1;
        if (w_hazard) w_latch_g = 1'b1;
        else          w_issue   = 1'b1;
      end
      S_HOLD:  w_issue = 1'b1;
      default: ;
    endcase
    w_req_nx = (w_state_nx == S_FETCH_LO) || (w_state_nx == S_FETCH_HI);
  end

  // Writes to r0 would retarget the PC in execute, so they never leave as a real operation.
  assign w_fire = w_issue && w_dec.def && (w_dec.dest != 5'd0);

  // Issue stage registers: one-cycle pulse, zero on every other edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc        <= RESET_PC;
      r_req        <= 1'b0;
      r_h          <= '0;
      r_g          <= '0;
      r_last_valid <= 1'b0;
      r_last_dest  <= '0;
      r_sel_p1     <= '0;
      r_dest_p1    <= '0;
      r_reg1_p1    <= '0;
      r_reg2_p1    <= '0;
    end else begin
      r_req        <= w_req_nx;
      if (w_fpc_inc) r_fpc <= r_fpc + 32'd2;
      if (w_latch_h) r_h   <= bus.imem_rdata_i;
      if (w_latch_g) r_g   <= bus.imem_rdata_i;
      r_last_valid <= w_fire;
      r_last_dest  <= w_fire ? w_dec.dest : 5'd0;
      r_sel_p1     <= w_fire ? w_dec.sel  : 5'd0;
      r_dest_p1    <= w_fire ? w_dec.dest : 5'd0;
      r_reg1_p1    <= w_fire ? w_reg1     : 32'h0;
      r_reg2_p1    <= w_fire ? w_reg2     : 32'h0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            r_illegal <= 1'b0;
    else if (w_state_nx == S_HALT && r_state != S_HALT)    r_illegal <= 1'b1;
  end
  assign illegal_o = r_illegal;
`endif

  assign bus.imem_req_o  = r_req;
  assign bus.imem_addr_o = r_fpc;
  assign fpc_o           = r_fpc;
  assign destination_o   = r_dest_p1;
  assign reg1_o          = r_reg1_p1;
  assign reg2_o          = r_reg2_p1;
  assign circuit_sel_o   = r_sel_p1;
  assign increment_bit_o = 1'b0;

endmodule

// File: tb/tb_fetch_decoder.sv
// Directed bench for fetch_decoder: reset/address sequencing, decode table, hazard bubble, r0 and undefined handling.
module tb_fetch_decoder;
  localparam logic [31:0] PC0 = 32'h0000_0100;
  localparam logic [31:0] PC1 = 32'hFFFF_FFFC;
  localparam logic [15:0] NOPW = 16'h01C1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] gr [32];
  logic [15:0] mem [16];
  logic [31:0] off0;

  fetch_decoder_if bus0 ();
  fetch_decoder_if bus1 ();

  logic [4:0]  dest0, sel0, dest1, sel1;
  logic [31:0] r1_0, r2_0, fpc0, r1_1, r2_1, fpc1;
  logic        inc0, inc1;
`ifdef ILLEGAL_TRAP_EN
  logic        ill0, ill1;
`endif

  assign bus0.imem_ack_i   = 1'b1;
  assign bus1.imem_ack_i   = 1'b1;
  assign bus1.imem_rdata_i = NOPW;

  always_comb begin
    off0 = bus0.imem_addr_o - PC0;
    bus0.imem_rdata_i = NOPW;
    if (off0 < 32'd32) bus0.imem_rdata_i = mem[off0[4:1]];
  end

  fetch_decoder #(.RESET_PC(PC0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .gr_i(gr),
    .destination_o(dest0), .reg1_o(r1_0), .reg2_o(r2_0),
    .increment_bit_o(inc0), .circuit_sel_o(sel0), .fpc_o(fpc0)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_o(ill0)
`endif
  );

  fetch_decoder #(.RESET_PC(PC1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .gr_i(gr),
    .destination_o(dest1), .reg1_o(r1_1), .reg2_o(r2_1),
    .increment_bit_o(inc1), .circuit_sel_o(sel1), .fpc_o(fpc1)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_o(ill1)
`endif
  );

  typedef struct {
    logic [15:0] h0;
    logic [15:0] h1;
    int          cnt;
    logic [4:0]  sel;
    logic [4:0]  dest;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  vec_t vt [7];

  int n_chk = 0;
  int n_fail = 0;
  int n_pulse;
  logic [4:0]  p_sel, p_dest;
  logic [31:0] p_r1, p_r2;
  logic        pend;
  logic [4:0]  pd;
  logic [31:0] pv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic init_gr();
    for (int i = 0; i < 32; i++) gr[i] = 32'h0101_0000 + 32'(i);
    gr[0] = 32'hDEAD_BEEF;
    gr[1] = 32'd5;
    gr[2] = 32'd7;
    gr[3] = 32'h1122_3344;
    gr[4] = 32'h0000_0010;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = NOPW;
  endtask

  // Advance to the next falling edge; model the execute stage writing back one edge after the pulse.
  task automatic cycle();
    @(negedge clk);
    if (pend) gr[pd] = pv;
    pend = 1'b0;
    if (sel0 != 5'd0) begin
      n_pulse++;
      if (n_pulse == 1) begin
        p_sel = sel0; p_dest = dest0; p_r1 = r1_0; p_r2 = r2_0;
      end
      pend = 1'b1;
      pd   = dest0;
      case (sel0)
        5'd1:    pv = r1_0 + r2_0;
        5'd2:    pv = r1_0 & r2_0;
        default: pv = r2_0;
      endcase
    end
  endtask

  task automatic start();
    rst_n = 1'b0;
    init_gr();
    pend = 1'b0; n_pulse = 0;
    p_sel = '0; p_dest = '0; p_r1 = '0; p_r2 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_undef(input string nm);
    start();
    repeat (12) cycle();
`ifdef ILLEGAL_TRAP_EN
    chk({nm, "_illegal"}, 32'(ill0), 32'd1);
    chk({nm, "_req_low"}, 32'(bus0.imem_req_o), 32'd0);
    chk({nm, "_pulses"}, 32'(n_pulse), 32'd0);
`else
    chk({nm, "_pulses"}, 32'(n_pulse), 32'd1);
    chk({nm, "_next_dest"}, 32'(p_dest), 32'd2);
`endif
  endtask

  initial begin
    vt[0] = '{16'h11C1, NOPW,     1, 5'd1, 5'd2, 32'd5,          32'd7};
    vt[1] = '{16'h225D, NOPW,     1, 5'd1, 5'd4, 32'hFFFF_FFFD,  32'h0000_0010};
    vt[2] = '{16'h1141, NOPW,     1, 5'd2, 5'd2, 32'd5,          32'd7};
    vt[3] = '{16'h1FE0, 16'h3340, 1, 5'd7, 5'd6, 32'd0,          32'h4433_2211};
    vt[4] = '{16'h1FE0, 16'h3342, 1, 5'd6, 5'd6, 32'd0,          32'h2211_4433};
    vt[5] = '{16'h11C0, NOPW,     1, 5'd1, 5'd2, 32'd0,          32'd7};
    vt[6] = '{16'h01C1, NOPW,     0, 5'd0, 5'd0, 32'd0,          32'd0};

    // Reset values and address sequencing (including wrap on the second instance)
    fill_mem();
    init_gr();
    pend = 1'b0; n_pulse = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",  32'(bus0.imem_req_o), 32'd0);
    chk("rst_addr", bus0.imem_addr_o, PC0);
    chk("rst_fpc",  fpc0, PC0);
    chk("rst_sel",  32'(sel0), 32'd0);
    chk("rst_dest", 32'(dest0), 32'd0);
    chk("rst_reg1", r1_0, 32'd0);
    chk("rst_reg2", r2_0, 32'd0);
    chk("rst_inc",  32'(inc0), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    chk("rst_illegal", 32'(ill0), 32'd0);
`endif
    rst_n = 1'b1;
    cycle();
    chk("seq_req",   32'(bus0.imem_req_o), 32'd1);
    chk("seq_addr0", bus0.imem_addr_o, 32'h100);
    chk("wrap_addr0", bus1.imem_addr_o, 32'hFFFF_FFFC);
    cycle();
    chk("seq_addr1", bus0.imem_addr_o, 32'h102);
    chk("wrap_addr1", bus1.imem_addr_o, 32'hFFFF_FFFE);
    cycle();
    chk("seq_addr2", bus0.imem_addr_o, 32'h104);
    chk("wrap_addr2", bus1.imem_addr_o, 32'h0000_0000);
    chk("seq_no_pulse", 32'(n_pulse), 32'd0);

    // Decode table
    for (int v = 0; v < 7; v++) begin
      fill_mem();
      mem[0] = vt[v].h0;
      mem[1] = vt[v].h1;
      start();
      repeat (12) cycle();
      chk($sformatf("vec%0d_count", v), 32'(n_pulse), 32'(vt[v].cnt));
      if (vt[v].cnt != 0) begin
        chk($sformatf("vec%0d_sel", v),  32'(p_sel),  32'(vt[v].sel));
        chk($sformatf("vec%0d_dest", v), 32'(p_dest), 32'(vt[v].dest));
        chk($sformatf("vec%0d_reg1", v), p_r1, vt[v].r1);
        chk($sformatf("vec%0d_reg2", v), p_r2, vt[v].r2);
      end
    end

    // Back-to-back dependency: ADD r1,r2 then AND r2,r3
    fill_mem();
    mem[0] = 16'h11C1;
    mem[1] = 16'h1942;
    start();
    for (int i = 0; i < 10 && n_pulse == 0; i++) cycle();
    chk("haz_first_seen", 32'(n_pulse), 32'd1);
    chk("haz_add_sel",  32'(p_sel), 32'd1);
    chk("haz_add_reg2", p_r2, 32'd7);
    cycle();
    chk("haz_bubble_sel", 32'(sel0), 32'd0);
    chk("haz_hold_req",   32'(bus0.imem_req_o), 32'd0);
    cycle();
    chk("haz_and_sel",  32'(sel0), 32'd2);
    chk("haz_and_dest", 32'(dest0), 32'd3);
    chk("haz_and_reg1", r1_0, 32'd12);
    chk("haz_and_reg2", r2_0, 32'h1122_3344);

    // Reset is asynchronous: outputs clear without a clock edge
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",  32'(bus0.imem_req_o), 32'd0);
    chk("async_rst_addr", bus0.imem_addr_o, PC0);
    chk("async_rst_sel",  32'(sel0), 32'd0);

    // Undefined opcode, then Format XII with an unknown second halfword
    fill_mem();
    mem[0] = 16'h0000;
    mem[1] = 16'h11C1;
    run_undef("undef_op");
    fill_mem();
    mem[0] = 16'h1FE0;
    mem[1] = 16'h3341;
    mem[2] = 16'h11C1;
    run_undef("undef_xii");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decoder.md
Name: fetch_decoder

Overview:
- Instruction fetch and decode stage directly upstream of the execute stage.
- Fetches 16-bit halfwords from instruction memory over a req/ack handshake and assembles 16- or 32-bit instructions.
- Decodes ADD reg, ADD imm5, AND, BSW and BSH, reads operands from the general-register array, and issues one-cycle operation pulses (destination, reg1, reg2, increment bit, circuit select) to the execute stage.
- Performs the BSW/BSH byte swap itself. The execute stage copies reg2 to the destination and computes flags from that value.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded at reset.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request, held until acked
imem_addr_o  output  32  halfword address of request (bit0 always 0)
imem_ack_i  input  1  memory accepts request; imem_rdata_i valid this cycle
imem_rdata_i  input  16  fetched halfword
gr_i  input  32x32 unpacked  general-register array from the execute stage, read combinationally
destination_o  output  5  destination register number
reg1_o  output  32  operand 1
reg2_o  output  32  operand 2
increment_bit_o  output  1  carry-in, always 0 for the supported set
circuit_sel_o  output  5  circuit select; 0 = no operation this cycle
fpc_o  output  32  current fetch PC (debug)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0, except fpc_o = imem_addr_o = RESET_PC. State = FETCH_LO. last_valid = 0. Reset mid-handshake drops the request; no issue follows.
- Output timing: outputs are registered. Issue fields are loaded on an issue edge and held for exactly one cycle. On every non-issue edge: circuit_sel_o = 0, other issue fields = 0.
- Decode of halfword h (reg2 = h[15:11], opcode = h[10:5], reg1 = h[4:0]):
  - 001110 ADD reg: sel 00001, dest = reg2, reg1_o = gr_i[reg1], reg2_o = gr_i[reg2].
  - 010010 ADD imm5: sel 00001, dest = reg2, reg1_o = sign-extended h[4:0], reg2_o = gr_i[reg2].
  - 001010 AND: sel 00010, dest = reg2, operands as ADD reg.
  - 111111 with h[4:0] = 0: 32-bit Format XII. Second halfword g: dest = g[15:11].
    - g[10:0] = 0x340 BSW: sel 00111, reg2_o = byte-reversed gr_i[reg2] ({b0,b1,b2,b3}), reg1_o = 0.
    - g[10:0] = 0x342 BSH: sel 00110, reg2_o = {b2,b3,b0,b1}, reg1_o = 0.
    - Any other g: undefined instruction.
  - Any other opcode: undefined instruction.
- r0 handling: gr_i[0] always read as 0. An instruction with dest = 0 is issued as a NOP (sel 0), because dest 0 with sel 00001 retargets the PC in the execute stage.
- State machine:
  - FETCH_LO: req high, addr = fpc.
    - On ack: fpc += 2.
    - Format XII first halfword: latch it, go to FETCH_HI.
    - Else, hazard: latch the halfword, go to HOLD.
    - Else: issue on this edge, stay in FETCH_LO.
  - FETCH_HI: req high, addr = fpc.
    - On ack: fpc += 2.
    - Hazard: latch the halfword, go to HOLD.
    - Else: issue, go to FETCH_LO.
  - HOLD: req low. Issue the latched instruction, go to FETCH_LO. Operands are re-read from gr_i in this cycle.
- Hazard: last_valid && last_dest != 0 && last_dest ∈ {registers read by this instruction}.
  - last_dest/last_valid are updated on every edge. They are set on an issue with sel != 0 and cleared otherwise.
  - A hazard therefore means the producer issued on the immediately preceding edge and its write-back has not yet reached gr_i.
- fpc wraps modulo 2^32 (0xFFFF_FFFE + 2 = 0).
- Request rules: no new request is raised while in HOLD. imem_addr_o is stable while req is high and un-acked.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an undefined instruction sets sticky output illegal_o = 1 and enters HALT. In HALT: req low, no issue, only reset exits. illegal_o is reset to 0.
- Undefined: undefined instructions are consumed as NOPs (sel 0) and fetching continues; illegal_o does not exist.

Test Plan:
- Reset with RESET_PC = 0x100, ack tied high → first imem_addr_o = 0x100, then 0x102, 0x104; every output 0 until the first issue.
- ADD r1,r2 (0x11C1), gr[1] = 5, gr[2] = 7, ack same cycle → one-cycle pulse sel = 00001, dest = 2, reg1_o = 5, reg2_o = 7.
- ADD imm5 -3 to r4 (0x225D) → reg1_o = 0xFFFF_FFFD, dest = 4.
- BSW r3→r6: halfwords 0x1FE0, then 0x3340, gr[3] = 0x11223344 → sel = 00111, dest = 6, reg2_o = 0x44332211. Same with second halfword 0x3342 (BSH) → sel = 00110, reg2_o = 0x22114433.
- ADD r1,r2 then AND r2,r3 with back-to-back acks → one bubble cycle (sel 0, HOLD), then the AND pulse with reg1_o = the post-write-back value of r2.
- Instruction with dest = 0 (ADD r1,r0) → sel stays 0. Undefined opcode → NOP; with ILLEGAL_TRAP_EN, illegal_o = 1 and req stays low thereafter.
